// File: rtl/mm_request_arbiter.sv
// Round-robin front end for one shared 3x3 matrix-multiply engine: grants a
// requester, latches its operands, runs the start/done handshake and returns the product.
module mm_request_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int MATRIX_SIZE    = 3,
  parameter int DATA_SIZE      = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                                            clk,
  input  logic                                                            reset,
  input  logic [NUM_REQ-1:0]                                              req,
  input  logic [NUM_REQ-1:0][MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_SIZE-1:0] req_a,
  input  logic [NUM_REQ-1:0][MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_SIZE-1:0] req_b,
  output logic [NUM_REQ-1:0]                                              grant,
  output logic                                                            busy,
  output logic                                                            mm_start,
  input  logic                                                            mm_done,
  output logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_SIZE-1:0]          mm_store_a,
  output logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_SIZE-1:0]          mm_store_b,
  input  logic [MATRIX_SIZE*MATRIX_SIZE-1:0][DATA_SIZE-1:0]               mm_result,
  output logic                                                            rsp_valid,
  input  logic                                                            rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]                                      rsp_id,
  output logic [MATRIX_SIZE*MATRIX_SIZE-1:0][DATA_SIZE-1:0]               rsp_matrix,
  output logic                                                            rsp_error
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(NUM_REQ - 1);

  typedef logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_SIZE-1:0] mat_t;
  typedef logic [MATRIX_SIZE*MATRIX_SIZE-1:0][DATA_SIZE-1:0]      flat_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t               state_r, state_s;
  logic [ID_W-1:0]      win_r, win_s;
  logic [ID_W-1:0]      last_r, last_s;
  logic [ID_W-1:0]      pick_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [NUM_REQ-1:0]   grant_s;
  logic                 busy_s;
  logic                 start_s;
  mat_t                 store_a_s, store_b_s;
  logic                 valid_s;
  logic [ID_W-1:0]      id_s;
  flat_t                matrix_s;
  logic                 error_s;

  // First set request searching upward from last+1; last itself has lowest priority.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] pick;
    int              idx;
    pick = last;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = (int'(last) + off) % NUM_REQ;
      if (r[idx]) begin
        pick = ID_W'(idx);
      end
    end
    return pick;
  endfunction

  // Next-state and next-output decode; every output is registered from these values.
  always_comb begin
    state_s   = state_r;
    win_s     = win_r;
    last_s    = last_r;
    cnt_s     = cnt_r;
    grant_s   = '0;
    store_a_s = mm_store_a;
    store_b_s = mm_store_b;
    id_s      = rsp_id;
    matrix_s  = rsp_matrix;
    error_s   = rsp_error;
    pick_s    = rr_pick(req, last_r);

    case (state_r)
      IDLE: begin
        if (req != '0) begin
          win_s   = pick_s;
          grant_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        store_a_s = req_a[win_r];
        store_b_s = req_b[win_r];
        last_s    = win_r;
        id_s      = win_r;
        cnt_s     = '0;
        state_s   = RUN;
      end
      RUN: begin
        // A done arriving on the final watchdog cycle still counts as success.
        if (mm_done) begin
          matrix_s = mm_result;
          error_s  = 1'b0;
          cnt_s    = '0;
          state_s  = DRAIN;
        end else if (cnt_r == CNT_LAST) begin
          matrix_s = '0;
          error_s  = 1'b1;
          cnt_s    = '0;
          state_s  = DRAIN;
        end else begin
          cnt_s    = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      DRAIN: begin
        if (!mm_done) begin
          state_s  = RESP;
        end else if (cnt_r == CNT_LAST) begin
          matrix_s = '0;
          error_s  = 1'b1;
          state_s  = RESP;
        end else begin
          cnt_s    = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    busy_s  = (state_s != IDLE);
    start_s = (state_s == RUN);
    valid_s = (state_s == RESP);
  end

  // State and output registers; reset discards any job in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      win_r      <= '0;
      last_r     <= LAST_INIT;
      cnt_r      <= '0;
      grant      <= '0;
      busy       <= 1'b0;
      mm_start   <= 1'b0;
      mm_store_a <= '0;
      mm_store_b <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_matrix <= '0;
      rsp_error  <= 1'b0;
    end else begin
      state_r    <= state_s;
      win_r      <= win_s;
      last_r     <= last_s;
      cnt_r      <= cnt_s;
      grant      <= grant_s;
      busy       <= busy_s;
      mm_start   <= start_s;
      mm_store_a <= store_a_s;
      mm_store_b <= store_b_s;
      rsp_valid  <= valid_s;
      rsp_id     <= id_s;
      rsp_matrix <= matrix_s;
      rsp_error  <= error_s;
    end
  end

endmodule

// File: tb/tb_mm_request_arbiter.sv
// Bench for mm_request_arbiter: behavioural multiply engine, table of single jobs,
// scoreboard of expected responses, and hand sequences for arbitration/backpressure/reset.
module tb_mm_request_arbiter;

  localparam int TO = 64;

  typedef logic [2:0][2:0][7:0] mat_t;
  typedef logic [8:0][7:0]      flat_t;

  typedef struct {
    int    id;
    mat_t  a;
    mat_t  b;
    int    lat;
    int    rdy;
    flat_t exp_mat;
    logic  exp_err;
    int    exp_run;
  } vec_t;

  typedef struct {
    logic [1:0] id;
    flat_t      mat;
    logic       err;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [3:0]            req;
  logic [3:0][2:0][2:0][7:0] req_a, req_b;
  logic [3:0]            grant;
  logic                  busy, mm_start, mm_done;
  mat_t                  mm_store_a, mm_store_b;
  flat_t                 mm_result;
  logic                  rsp_valid, rsp_ready;
  logic [1:0]            rsp_id;
  flat_t                 rsp_matrix;
  logic                  rsp_error;

  int   checks = 0;
  int   failures = 0;
  int   eng_lat = 0;
  int   eng_cnt;
  int   run_total = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vt[6];

  mm_request_arbiter #(.NUM_REQ(4), .MATRIX_SIZE(3), .DATA_SIZE(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
    .grant(grant), .busy(busy), .mm_start(mm_start), .mm_done(mm_done),
    .mm_store_a(mm_store_a), .mm_store_b(mm_store_b), .mm_result(mm_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_matrix(rsp_matrix), .rsp_error(rsp_error)
  );

  always #5 clk = ~clk;

  function automatic flat_t matmul(input mat_t a, input mat_t b);
    flat_t      c;
    logic [7:0] s;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        s = 8'd0;
        for (int k = 0; k < 3; k++) s = s + a[i][k] * b[k][j];
        c[i*3+j] = s;
      end
    end
    return c;
  endfunction

  function automatic mat_t mkmat(input int base, input int step);
    mat_t m;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) m[i][j] = 8'(base + step * (i*3 + j));
    return m;
  endfunction

  function automatic mat_t ident();
    mat_t m;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) m[i][j] = (i == j) ? 8'd1 : 8'd0;
    return m;
  endfunction

  // Engine raises done lat+1 edges into RUN, so done is sampled lat+2 edges into RUN.
  function automatic vec_t mkvec(input int id, input int ab, input int as_, input int bb,
                                 input int bs, input int lat, input int rdy);
    vec_t v;
    v.id = id; v.a = mkmat(ab, as_); v.b = mkmat(bb, bs); v.lat = lat; v.rdy = rdy;
    v.exp_err = (lat + 2 > TO);
    v.exp_mat = v.exp_err ? '0 : matmul(v.a, v.b);
    v.exp_run = v.exp_err ? TO : lat + 2;
    return v;
  endfunction

  // Behavioural engine: product of the latched operands, done held until start drops.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mm_done   <= 1'b0;
      mm_result <= '0;
      eng_cnt   <= 0;
    end else if (!mm_start) begin
      mm_done <= 1'b0;
      eng_cnt <= 0;
    end else if (!mm_done) begin
      if (eng_cnt == eng_lat) begin
        mm_done   <= 1'b1;
        mm_result <= matmul(mm_store_a, mm_store_b);
      end else begin
        eng_cnt <= eng_cnt + 1;
      end
    end
  end

  always @(negedge clk) if (mm_start) run_total <= run_total + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_wait(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event not seen within bound, expected it to occur", name);
  endtask

  // Scoreboard: compare each accepted response against the oldest expectation.
  always @(negedge clk) begin
    #2;
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        fail_wait("unexpected_rsp");
      end else begin
        mon_e = sb.pop_front();
        check("rsp_id", rsp_id, mon_e.id);
        check("rsp_matrix", rsp_matrix, mon_e.mat);
        check("rsp_error", rsp_error, mon_e.err);
      end
    end
  end

  task automatic push_exp(input int id, input flat_t mat, input logic err);
    exp_t e;
    e.id = 2'(id); e.mat = mat; e.err = err;
    sb.push_back(e);
  endtask

  task automatic wait_grant(output logic [3:0] g);
    g = '0;
    for (int i = 0; i < 400 && g == 4'd0; i++) begin
      @(negedge clk);
      g = grant;
    end
    if (g == 4'd0) fail_wait("grant_timeout");
  endtask

  task automatic wait_valid();
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    if (!seen) fail_wait("valid_timeout");
  endtask

  task automatic wait_done();
    bit done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !busy;
    end
    if (!done) fail_wait("done_timeout");
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_ctl"}, {grant, busy, mm_start, rsp_valid, rsp_error, rsp_id}, '0);
    check({pfx, "_store"}, {mm_store_a, mm_store_b}, '0);
    check({pfx, "_matrix"}, rsp_matrix, '0);
  endtask

  task automatic run_job(input vec_t v);
    logic [3:0] g;
    int         start_cnt;
    @(negedge clk);
    req_a[v.id] = v.a;
    req_b[v.id] = v.b;
    eng_lat     = v.lat;
    rsp_ready   = (v.rdy == 0);
    start_cnt   = run_total;
    push_exp(v.id, v.exp_mat, v.exp_err);
    req = 4'b0001 << v.id;
    wait_grant(g);
    check("grant", g, 4'b0001 << v.id);
    check("busy_in_load", busy, 1'b1);
    check("start_in_load", mm_start, 1'b0);
    req = '0;
    @(negedge clk);
    check("start_after_grant", mm_start, 1'b1);
    check("grant_pulse", grant, 4'd0);
    check("store_a", mm_store_a, v.a);
    check("store_b", mm_store_b, v.b);
    if (v.rdy > 0) begin
      wait_valid();
      repeat (v.rdy) @(negedge clk);
      rsp_ready = 1'b1;
    end
    wait_done();
    check("run_cycles", run_total - start_cnt, v.exp_run);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [3:0]  g;
    logic [74:0] snap;
    bit          stable;
    mat_t        a_tp;

    vt[0] = mkvec(1, 2, 3, 1, 1, 0, 0);
    vt[1] = mkvec(2, 250, 7, 9, 13, 5, 3);
    vt[2] = mkvec(0, 5, 1, 3, 2, TO - 2, 0);
    vt[3] = mkvec(1, 7, 4, 2, 5, TO - 1, 1);
    vt[4] = mkvec(2, 11, 2, 6, 3, 1000, 0);
    vt[5] = mkvec(3, 4, 9, 8, 1, 2, 0);

    req = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("post_reset");

    // Single job from the test plan: B = identity, expected product written out directly.
    a_tp = mkmat(1, 1);
    @(negedge clk);
    req_a[0] = a_tp; req_b[0] = ident(); eng_lat = 3;
    push_exp(0, flat_t'(a_tp), 1'b0);
    req = 4'b0001;
    wait_grant(g);
    check("single_grant", g, 4'b0001);
    check("single_start_low", mm_start, 1'b0);
    req = '0;
    @(negedge clk);
    check("single_start_high", mm_start, 1'b1);
    check("single_grant_drop", grant, 4'd0);
    wait_done();

    for (int i = 0; i < 6; i++) run_job(vt[i]);

    // All four requesting at once, each released after its grant: order 0,1,2,3.
    @(negedge clk);
    eng_lat = 3; rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_a[k] = mkmat(10 * k + 1, k + 2);
      req_b[k] = mkmat(3 * k + 2, 5 - k);
      push_exp(k, matmul(req_a[k], req_b[k]), 1'b0);
    end
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_grant(g);
      check("simul_grant", g, 4'b0001 << k);
      req[k] = 1'b0;
    end
    wait_done();

    // Fairness: after requester 2, req=0101 serves 0 (wrap) then 2.
    run_job(mkvec(2, 20, 1, 1, 1, 1, 0));
    @(negedge clk);
    req_a[0] = mkmat(3, 3); req_b[0] = mkmat(1, 2);
    req_a[2] = mkmat(6, 5); req_b[2] = mkmat(2, 7);
    push_exp(0, matmul(req_a[0], req_b[0]), 1'b0);
    push_exp(2, matmul(req_a[2], req_b[2]), 1'b0);
    req = 4'b0101;
    wait_grant(g);
    check("fair_first", g, 4'b0001);
    req[0] = 1'b0;
    wait_grant(g);
    check("fair_second", g, 4'b0100);
    req[2] = 1'b0;
    wait_done();

    // Backpressure: response held for 10 cycles while requester 1 waits.
    @(negedge clk);
    req_a[3] = mkmat(12, 3); req_b[3] = mkmat(5, 1);
    eng_lat = 4; rsp_ready = 1'b0;
    push_exp(3, matmul(req_a[3], req_b[3]), 1'b0);
    req = 4'b1000;
    wait_grant(g);
    check("bp_grant", g, 4'b1000);
    req = '0;
    wait_valid();
    snap = {rsp_id, rsp_matrix, rsp_error};
    req_a[1] = mkmat(30, 2); req_b[1] = mkmat(4, 4);
    push_exp(1, matmul(req_a[1], req_b[1]), 1'b0);
    req = 4'b0010;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || {rsp_id, rsp_matrix, rsp_error} !== snap || grant !== 4'd0)
        stable = 1'b0;
    end
    check("bp_hold", stable, 1'b1);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_drop", rsp_valid, 1'b0);
    check("bp_no_early_grant", grant, 4'd0);
    @(negedge clk);
    check("bp_regrant", grant, 4'b0010);
    req = '0;
    wait_done();

    // Reset three cycles into RUN: job discarded, outputs cleared at once.
    @(negedge clk);
    req_a[1] = mkmat(9, 9); req_b[1] = mkmat(2, 2); eng_lat = 40;
    req = 4'b0010;
    wait_grant(g);
    check("rst_job_grant", g, 4'b0010);
    req = '0;
    @(negedge clk);
    check("rst_job_start", mm_start, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    check("start_before_rst", mm_start, 1'b1);
    reset = 1'b1;
    #1;
    check_reset_vals("rst_run");
    @(negedge clk);
    reset = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) stable = 1'b0;
    end
    check("rst_quiet", stable, 1'b1);
    run_job(mkvec(3, 1, 2, 3, 1, 2, 0));

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
